// File: rtl/mul_div_unit.sv
// mul_div_unit
// Multi-cycle multiply/divide unit that owns the architectural HI/LO pair.
// An accepted mult/multu runs for 5 busy cycles and div/divu for 10. The
// result is written to HI/LO at the edge that ends the last busy cycle.
// mthi/mtlo write HI/LO directly at the next edge when the unit is idle.
//
// Ports
//   clk     : clock, rising edge
//   reset   : synchronous, active-high reset
//   md_op   : 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   a       : rs operand, also the mthi/mtlo source
//   b       : rt operand
//   rd_sel  : 0 reads LO, 1 reads HI on md_rd
//   flush   : EX-stage instruction squashed; blocks acceptance this cycle
//   busy    : operation in flight
//   start   : mult/div op accepted this cycle
//   md_rd   : selected HI or LO value
//   hi, lo  : architectural HI/LO registers
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_sel,
    input  logic        flush,
    output logic        busy,
    output logic        start,
    output logic [31:0] md_rd,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_NONE7 = 3'd7
    } md_op_t;

    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [3:0]  count;

    logic        is_mul_div;
    logic        is_div;

    // Multiply: sign- or zero-extend to 64 bits; the low 64 bits of the
    // extended product are the exact 64-bit signed/unsigned result.
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    // Divide on magnitudes so that 0x80000000 / -1 needs no special case:
    // its magnitude 2^31 is representable as an unsigned 32-bit value.
    logic        div_signed;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;

    assign is_mul_div = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                        (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign is_div     = (md_op == OP_DIV)  || (md_op == OP_DIVU);

    assign busy  = (count != 4'd0);
    assign start = is_mul_div && !busy && !flush;
    assign md_rd = rd_sel ? hi : lo;

    always_comb begin
        mul_signed = (op_q == OP_MULT);
        mul_a      = {{32{mul_signed & a_q[31]}}, a_q};
        mul_b      = {{32{mul_signed & b_q[31]}}, b_q};
        product    = mul_a * mul_b;
    end

    always_comb begin
        div_signed  = (op_q == OP_DIV);
        neg_a       = div_signed & a_q[31];
        neg_b       = div_signed & b_q[31];
        mag_a       = neg_a ? (~a_q + 32'd1) : a_q;
        mag_b       = neg_b ? (~b_q + 32'd1) : b_q;
        div_by_zero = (b_q == 32'd0);
        // Keep the divider's input nonzero; the result is discarded anyway.
        safe_b      = div_by_zero ? 32'd1 : mag_b;
        quot_mag    = mag_a / safe_b;
        rem_mag     = mag_a % safe_b;
        quot        = (neg_a ^ neg_b) ? (~quot_mag + 32'd1) : quot_mag;
        rem         = neg_a ? (~rem_mag + 32'd1) : rem_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi    <= 32'd0;
            lo    <= 32'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            count <= 4'd0;
        end else if (start) begin
            op_q  <= md_op;
            a_q   <= a;
            b_q   <= b;
            count <= is_div ? 4'd10 : 4'd5;
        end else if (busy) begin
            count <= count - 4'd1;
            if (count == 4'd1) begin
                case (op_q)
                    OP_MULT, OP_MULTU: begin
                        hi <= product[63:32];
                        lo <= product[31:0];
                    end
                    OP_DIV, OP_DIVU: begin
                        if (!div_by_zero) begin
                            hi <= rem;
                            lo <= quot;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (!flush) begin
            if (md_op == OP_MTHI) hi <= a;
            if (md_op == OP_MTLO) lo <= a;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
// Directed-vector bench for mul_div_unit with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at that same point, so they reflect the state updated by the last edge.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_sel;
    logic        flush;
    logic        busy;
    logic        start;
    logic [31:0] md_rd;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    mul_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .md_op  (md_op),
        .a      (a),
        .b      (b),
        .rd_sel (rd_sel),
        .flush  (flush),
        .busy   (busy),
        .start  (start),
        .md_rd  (md_rd),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a mult/div op for one cycle, check it is accepted, then
    // scramble a/b and count busy cycles until completion.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] va, input logic [31:0] vb,
                          input int exp_cycles);
        int n;
        md_op = op;
        a     = va;
        b     = vb;
        #1;
        chk({tag, "_start"}, {31'd0, start}, 32'd1);
        tick();
        md_op = 3'd0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0000_0003;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, n, exp_cycles);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] va);
        md_op = op;
        a     = va;
        tick();
        md_op = 3'd0;
    endtask

    initial begin
        reset  = 1'b1;
        md_op  = 3'd1;
        a      = 32'h5;
        b      = 32'h7;
        rd_sel = 1'b0;
        flush  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        md_op = 3'd0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_md_rd", md_rd, 32'd0);

        md_op = 3'd7;
        #1;
        chk("op7_start", {31'd0, start}, 32'd0);
        tick();
        md_op = 3'd0;
        chk("op7_busy", {31'd0, busy}, 32'd0);

        run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'd2, 5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        run_op("mult_negneg", 3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 5);
        chk("mult_negneg_hi", hi, 32'd0);
        chk("mult_negneg_lo", lo, 32'd15);

        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        run_op("div_negb", 3'd3, 32'd7, 32'hFFFF_FFFE, 10);
        chk("div_negb_lo", lo, 32'hFFFF_FFFD);
        chk("div_negb_hi", hi, 32'd1);

        run_op("divu", 3'd4, 32'd7, 32'd2, 10);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);

        mt(3'd5, 32'h11);
        chk("mthi_hi", hi, 32'h11);
        mt(3'd6, 32'h22);
        chk("mtlo_lo", lo, 32'h22);
        run_op("divu_zero", 3'd4, 32'd7, 32'd0, 10);
        chk("divu_zero_hi", hi, 32'h11);
        chk("divu_zero_lo", lo, 32'h22);

        md_op = 3'd1;
        a     = 32'd3;
        b     = 32'd4;
        flush = 1'b1;
        #1;
        chk("flush_start", {31'd0, start}, 32'd0);
        tick();
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_hi", hi, 32'h11);
        chk("flush_lo", lo, 32'h22);
        flush = 1'b0;
        run_op("reissue", 3'd1, 32'd3, 32'd4, 5);
        chk("reissue_hi", hi, 32'd0);
        chk("reissue_lo", lo, 32'd12);

        md_op = 3'd6;
        a     = 32'h1234;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        md_op = 3'd0;
        chk("mtlo_flush_lo", lo, 32'd12);

        md_op = 3'd1;
        a     = 32'd2;
        b     = 32'd3;
        tick();
        chk("mtlo_busy_pre", {31'd0, busy}, 32'd1);
        mt(3'd6, 32'h1234);
        begin
            int n;
            n = 0;
            while (busy && n < 40) begin
                n++;
                tick();
            end
        end
        chk("mtlo_busy_lo", lo, 32'd6);
        chk("mtlo_busy_hi", hi, 32'd0);
        mt(3'd6, 32'h1234);
        chk("mtlo_lo2", lo, 32'h1234);
        rd_sel = 1'b0;
        #1;
        chk("md_rd_lo", md_rd, 32'h1234);
        rd_sel = 1'b1;
        #1;
        chk("md_rd_hi", md_rd, 32'd0);
        mt(3'd5, 32'hABCD);
        #1;
        chk("md_rd_hi2", md_rd, 32'hABCD);

        md_op = 3'd3;
        a     = 32'd100;
        b     = 32'd7;
        tick();
        md_op = 3'd0;
        tick();
        tick();
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        repeat (12) tick();
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);

        md_op = 3'd4;
        a     = 32'd9;
        b     = 32'd2;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        md_op = 3'd0;
        chk("rst_op_busy", {31'd0, busy}, 32'd0);
        repeat (12) tick();
        chk("rst_op_lo", lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
